// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : registered 6502-style ALU with BCD add/subtract, shifts/rotates
//           and N/Z/V/C/half-carry flags.
//
// Binary, logic, shift and illegal ops complete on the accept edge. Decimal
// ADC/SBC walks the operands one nibble per cycle, LSB nibble first.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake (ready only in IDLE)
//   op                     0 ADC 1 SBC 2 AND 3 OR 4 EOR 5 ASL 6 LSR 7 ROL 8 ROR
//   reg_a, reg_b           operands (B unused by shifts)
//   carry_in               C in: ADC carry, SBC not-borrow, rotate fill
//   decimal_mode           BCD mode for ADC/SBC
//   out_valid / out_ready  result handshake (valid only in DONE)
//   result, carry_out, overflow, zero, negative, half_carry  registered outputs
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic             carry_in,
    input  logic             decimal_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             half_carry
);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("alu_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_q, sub_d;     // decimal op is SBC
    logic             c_q, c_d;         // nibble carry chain (SBC: not-borrow)
    logic             hc_q, hc_d;       // nibble-0 carry captured mid-run
    logic             v_q, v_d;         // binary V latched at accept
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, ovf_q, ovf_d;
    logic             zero_q, zero_d, neg_q, neg_d, half_q, half_d;

    // Binary add path on the live inputs (used on the accept edge)
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   a_ext, b_ext, sum;
    logic             v_bin, h_bin;

    // One BCD nibble step on the latched operands
    logic [4:0]       s_add, d_sub;
    logic [3:0]       nib;
    logic             nc;
    logic [WIDTH+3:0] acc_cat;

    // Output load bundle
    logic             load;
    logic [WIDTH-1:0] r_new;
    logic             c_new, v_new, h_new;

    always_comb begin
        b_eff = (op == 4'd1) ? ~reg_b : reg_b;
        a_ext = {1'b0, reg_a};
        b_ext = {1'b0, b_eff};
        sum   = a_ext + b_ext + {{WIDTH{1'b0}}, carry_in};
        v_bin = (reg_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != reg_a[WIDTH-1]);
        // Carry into bit 4 recovered from the sum; the extra 0 bit covers WIDTH=4
        h_bin = a_ext[4] ^ b_ext[4] ^ sum[4];

        s_add = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};
        d_sub = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, ~c_q};
        if (sub_q) begin
            nc  = ~d_sub[4];                              // negative -> borrow
            nib = d_sub[4] ? (d_sub[3:0] + 4'd10) : d_sub[3:0];
        end else begin
            nc  = (s_add > 5'd9);
            nib = nc ? (s_add[3:0] + 4'd6) : s_add[3:0];
        end
        acc_cat = {nib, acc_q};

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        c_d      = c_q;
        hc_d     = hc_q;
        v_d      = v_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        half_d   = half_q;
        load     = 1'b0;
        r_new    = '0;
        c_new    = 1'b0;
        v_new    = 1'b0;
        h_new    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = reg_a;
                    b_d   = reg_b;
                    c_d   = carry_in;
                    sub_d = (op == 4'd1);
                    v_d   = v_bin;
                    cnt_d = '0;
                    if (decimal_mode && (op == 4'd0 || op == 4'd1)) begin
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                        load    = 1'b1;
                        case (op)
                            4'd0, 4'd1: begin
                                r_new = sum[WIDTH-1:0];
                                c_new = sum[WIDTH];
                                v_new = v_bin;
                                h_new = h_bin;
                            end
                            4'd2: r_new = reg_a & reg_b;
                            4'd3: r_new = reg_a | reg_b;
                            4'd4: r_new = reg_a ^ reg_b;
                            4'd5: begin r_new = reg_a << 1;                    c_new = reg_a[WIDTH-1]; end
                            4'd6: begin r_new = reg_a >> 1;                    c_new = reg_a[0];       end
                            4'd7: begin r_new = {reg_a[WIDTH-2:0], carry_in}; c_new = reg_a[WIDTH-1]; end
                            4'd8: begin r_new = {carry_in, reg_a[WIDTH-1:1]}; c_new = reg_a[0];       end
                            default: r_new = '1;
                        endcase
                    end
                end
            end
            CALC: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                c_d   = nc;
                acc_d = acc_cat[WIDTH+3:4];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) hc_d = nc;
                if (cnt_q == CW'(NIB - 1)) begin
                    state_d = DONE;
                    load    = 1'b1;
                    r_new   = acc_cat[WIDTH+3:4];
                    c_new   = nc;
                    v_new   = v_q;
                    h_new   = (cnt_q == '0) ? nc : hc_q;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            result_d = r_new;
            carry_d  = c_new;
            ovf_d    = v_new;
            half_d   = h_new;
            zero_d   = (r_new == '0);
            neg_d    = r_new[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            hc_q     <= 1'b0;
            v_q      <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            half_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            hc_q     <= hc_d;
            v_q      <= v_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            half_q   <= half_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign result     = result_q;
    assign carry_out  = carry_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign half_carry = half_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 6502 combinational ALU. Adds width generalisation, true BCD add/subtract, shift/rotate ops and N/Z flag generation. Decimal arithmetic is nibble-serial over several cycles. Sits between the instruction decoder/sequencer and the register file, with a valid/ready handshake on both sides so the sequencer can stall on multi-cycle decimal ops.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request (high only in IDLE)
op  input  4  0 ADC, 1 SBC, 2 AND, 3 OR, 4 EOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR; 9-15 illegal
reg_a  input  WIDTH  operand A (signed)
reg_b  input  WIDTH  operand B (signed; ignored by shifts)
carry_in  input  1  C flag in (ADC carry, SBC not-borrow, rotate fill)
decimal_mode  input  1  BCD mode; affects ADC/SBC only
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carry_out  output  1  C flag
overflow  output  1  V flag (signed over/underflow)
zero  output  1  Z flag, result == 0
negative  output  1  N flag, result[WIDTH-1]
half_carry  output  1  carry out of bit 3 / nibble 0

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset state:
  - FSM in IDLE.
  - out_valid, result, carry_out, overflow, zero, negative, half_carry all 0.
  - in_ready is 1 (decoded from IDLE).
  - Reset asserted in any state aborts the operation immediately; the partial result is discarded.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid, latch op, operands, carry_in and decimal_mode. If the op is decimal ADC/SBC, go to CALC; otherwise compute and go to DONE.
  - CALC: process one nibble per cycle, LSB nibble first, with a nibble counter of WIDTH/4 steps. After the last nibble, register the outputs and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency, counted from the accept edge (cycle t):
  - Non-decimal ops: out_valid at t+1.
  - Decimal ADC/SBC: out_valid at t+WIDTH/4+1 (t+3 for WIDTH=8).
- Throughput: in_ready is 0 outside IDLE, so there is no overlap between requests.
- Outputs are stable while out_valid=1 and out_ready=0.
- Input changes after acceptance have no effect.
- Binary ADC:
  - {C,R} = A + B + Cin.
  - V = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - half_carry = carry out of bit 3.
- Binary SBC: computed as ADC with ~B. C=1 means no borrow.
- Decimal ADC, per nibble:
  - s = a + b + c.
  - If s > 9: s += 6 and nibble carry = 1.
  - Final carry is carry_out. Nibble-0 carry is half_carry.
- Decimal SBC, per nibble:
  - d = a - b - (1 - c).
  - If d < 0: d += 10 (mod 16) and borrow = 1.
  - carry_out = !final borrow. half_carry = !nibble-0 borrow.
- Decimal V takes the value of the binary computation on the same operands. N and Z are taken from the final decimal result.
- Non-BCD digits (>9) go through the same per-nibble rules; no error is flagged.
- AND / OR / EOR: C=0, V=0, half_carry=0.
- Shifts and rotates ignore B and decimal_mode; V=0, half_carry=0:
  - ASL: R = A<<1, C = A[msb].
  - LSR: R = A>>1 (logical), C = A[0].
  - ROL: R = {A[msb-1:0], Cin}, C = A[msb].
  - ROR: R = {Cin, A[msb:1]}, C = A[0].
- Illegal op: R = all ones; C, V, half_carry = 0; N=1, Z=0; 1-cycle latency.
- Z and N are always derived from the final registered result.

Test Plan:
- WIDTH=8, binary ADC 0x50+0x50, cin=0 -> result 0xA0, C=0, V=1, N=1, Z=0; out_valid exactly 1 cycle after accept.
- WIDTH=8, decimal ADC 0x58+0x46, cin=1 -> result 0x05, C=1, half_carry=1, Z=0; out_valid 3 cycles after accept.
- WIDTH=8, decimal SBC 0x40-0x13, cin=1 -> 0x27, C=1. Then 0x12-0x21, cin=1 -> 0x91, C=0, N=1.
- WIDTH=8:
  - ROR 0x01, cin=1 -> 0x80, C=1, N=1.
  - LSR 0x01 -> 0x00, Z=1, C=1.
  - Illegal op 0xF -> 0xFF, C=0, V=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags unchanged, in_ready=0 throughout. Pulse out_ready -> in_ready=1 next cycle; a new request is accepted.
- WIDTH=16, decimal ADC 0x9999+0x0001: assert rst_n=0 during CALC -> all outputs 0 asynchronously. After release, in_ready=1. Rerun to completion -> 0x0000, C=1, Z=1.
